// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Byte-serial controller arbitrating instruction fetch and
//            load/store clients onto a single-port 8-bit RAM/IO bus.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int IF_BYTES   = 4,
    parameter int IO_HI      = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_en,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  mc_en,
    input  logic                  mc_wr,
    input  logic [ADDR_WIDTH-1:0] mc_addr,
    input  logic [2:0]            mc_len,
    input  logic [31:0]           mc_w_data,
    output logic                  mc_done,
    output logic [31:0]           mc_r_data
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [2:0] c_IF_LEN = 3'(IF_BYTES);

    state_t                r_state, w_state_nxt;
    logic                  r_is_if, w_is_if_nxt;
    logic                  r_wr, w_wr_nxt;
    logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
    logic [2:0]            r_len, w_len_nxt;
    logic [31:0]           r_wdata, w_wdata_nxt;
    logic [2:0]            r_issue, w_issue_nxt;
    logic [2:0]            r_cap, w_cap_nxt;
    logic                  r_adrv, w_adrv_nxt;
    logic                  r_dvld, w_dvld_nxt;
    logic [31:0]           r_rbuf, w_rbuf_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_a, w_mem_a_nxt;
    logic [7:0]            r_mem_dout, w_mem_dout_nxt;
    logic                  r_mem_wr, w_mem_wr_nxt;
    logic                  r_if_done, w_if_done_nxt;
    logic [31:0]           r_if_data, w_if_data_nxt;
    logic                  r_mc_done, w_mc_done_nxt;
    logic [31:0]           r_mc_r_data, w_mc_r_data_nxt;
    // Bus-side tracking of the read byte that arrives during the first stall cycle
    logic                  r_rdy_q;
    logic [7:0]            r_skid;

    logic                  w_accept, w_abort, w_io_blk, w_issue;
    logic                  w_cur_wr;
    logic [ADDR_WIDTH-1:0] w_cur_base, w_byte_addr;
    logic [2:0]            w_cur_len, w_cur_idx, w_mc_len;
    logic [31:0]           w_cur_wdata, w_rbuf_upd;
    logic [7:0]            w_wbyte, w_din;

    always_comb begin
        w_accept = (r_state == S_IDLE) && (mc_en || if_en) &&
                   !r_if_done && !r_mc_done && !rollback;
        w_abort  = (r_state == S_BUSY) && rollback && !r_wr;

        case (mc_len)
            3'd1:    w_mc_len = 3'd1;
            3'd2:    w_mc_len = 3'd2;
            default: w_mc_len = 3'd4;
        endcase

        // On the accept edge byte 0 is issued straight from the request
        w_cur_wr    = w_accept ? (mc_en && mc_wr) : r_wr;
        w_cur_base  = w_accept ? (mc_en ? mc_addr : if_addr) : r_base;
        w_cur_len   = w_accept ? (mc_en ? w_mc_len : c_IF_LEN) : r_len;
        w_cur_wdata = w_accept ? mc_w_data : r_wdata;
        w_cur_idx   = w_accept ? 3'd0 : r_issue;

        w_byte_addr = w_cur_base + {{(ADDR_WIDTH-3){1'b0}}, w_cur_idx};
        w_io_blk    = w_cur_wr && (w_byte_addr[IO_HI -: 2] == 2'b11) && io_buffer_full;
        w_issue     = (w_accept || ((r_state == S_BUSY) && !w_abort)) &&
                      (w_cur_idx < w_cur_len) && !w_io_blk;

        case (w_cur_idx[1:0])
            2'd0:    w_wbyte = w_cur_wdata[7:0];
            2'd1:    w_wbyte = w_cur_wdata[15:8];
            2'd2:    w_wbyte = w_cur_wdata[23:16];
            default: w_wbyte = w_cur_wdata[31:24];
        endcase

        w_din      = r_rdy_q ? mem_din : r_skid;
        w_rbuf_upd = r_rbuf;
        w_rbuf_upd[{r_cap[1:0], 3'b000} +: 8] = w_din;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_is_if_nxt     = r_is_if;
        w_wr_nxt        = r_wr;
        w_base_nxt      = r_base;
        w_len_nxt       = r_len;
        w_wdata_nxt     = r_wdata;
        w_issue_nxt     = r_issue;
        w_cap_nxt       = r_cap;
        w_adrv_nxt      = 1'b0;
        w_dvld_nxt      = 1'b0;
        w_rbuf_nxt      = r_rbuf;
        w_mem_a_nxt     = r_mem_a;
        w_mem_dout_nxt  = r_mem_dout;
        w_mem_wr_nxt    = 1'b0;
        w_if_done_nxt   = 1'b0;
        w_if_data_nxt   = r_if_data;
        w_mc_done_nxt   = 1'b0;
        w_mc_r_data_nxt = r_mc_r_data;

        if (w_accept) begin
            w_state_nxt = S_BUSY;
            w_is_if_nxt = !mc_en;
            w_wr_nxt    = w_cur_wr;
            w_base_nxt  = w_cur_base;
            w_len_nxt   = w_cur_len;
            w_wdata_nxt = w_cur_wdata;
            w_issue_nxt = 3'd0;
            w_cap_nxt   = 3'd0;
            w_rbuf_nxt  = 32'd0;
        end

        if (w_issue) begin
            w_mem_a_nxt = w_byte_addr;
            w_issue_nxt = w_cur_idx + 3'd1;
            if (w_cur_wr) begin
                w_mem_wr_nxt   = 1'b1;
                w_mem_dout_nxt = w_wbyte;
            end else begin
                w_adrv_nxt = 1'b1;
            end
        end

        if (r_state == S_BUSY) begin
            if (w_abort) begin
                w_state_nxt = S_IDLE;
            end else if (r_wr) begin
                if (r_issue == r_len) begin
                    w_state_nxt   = S_IDLE;
                    w_mc_done_nxt = 1'b1;
                end
            end else begin
                w_dvld_nxt = r_adrv;
                if (r_dvld) begin
                    w_rbuf_nxt = w_rbuf_upd;
                    w_cap_nxt  = r_cap + 3'd1;
                    if (r_cap == (r_len - 3'd1)) begin
                        w_state_nxt = S_IDLE;
                        if (r_is_if) begin
                            w_if_done_nxt = 1'b1;
                            w_if_data_nxt = w_rbuf_upd;
                        end else begin
                            w_mc_done_nxt   = 1'b1;
                            w_mc_r_data_nxt = w_rbuf_upd;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_if     <= 1'b0;
            r_wr        <= 1'b0;
            r_base      <= '0;
            r_len       <= 3'd0;
            r_wdata     <= 32'd0;
            r_issue     <= 3'd0;
            r_cap       <= 3'd0;
            r_adrv      <= 1'b0;
            r_dvld      <= 1'b0;
            r_rbuf      <= 32'd0;
            r_mem_a     <= '0;
            r_mem_dout  <= 8'd0;
            r_mem_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_data   <= 32'd0;
            r_mc_done   <= 1'b0;
            r_mc_r_data <= 32'd0;
            r_rdy_q     <= 1'b1;
            r_skid      <= 8'd0;
        end else begin
            r_rdy_q <= rdy;
            if (!rdy && r_rdy_q) begin
                r_skid <= mem_din;
            end
            if (rdy) begin
                r_state     <= w_state_nxt;
                r_is_if     <= w_is_if_nxt;
                r_wr        <= w_wr_nxt;
                r_base      <= w_base_nxt;
                r_len       <= w_len_nxt;
                r_wdata     <= w_wdata_nxt;
                r_issue     <= w_issue_nxt;
                r_cap       <= w_cap_nxt;
                r_adrv      <= w_adrv_nxt;
                r_dvld      <= w_dvld_nxt;
                r_rbuf      <= w_rbuf_nxt;
                r_mem_a     <= w_mem_a_nxt;
                r_mem_dout  <= w_mem_dout_nxt;
                r_mem_wr    <= w_mem_wr_nxt;
                r_if_done   <= w_if_done_nxt;
                r_if_data   <= w_if_data_nxt;
                r_mc_done   <= w_mc_done_nxt;
                r_mc_r_data <= w_mc_r_data_nxt;
            end
        end
    end

    assign mem_a     = r_mem_a;
    assign mem_dout  = r_mem_dout;
    assign mem_wr    = r_mem_wr & rdy;
    assign if_done   = r_if_done;
    assign if_data   = r_if_data;
    assign mc_done   = r_mc_done;
    assign mc_r_data = r_mc_r_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Directed self-checking bench for mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_en;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mc_en;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [2:0]  mc_len;
    logic [31:0] mc_w_data;
    logic        mc_done;
    logic [31:0] mc_r_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mc_m, if_m, wr_m;
    logic [31:0] wa [0:31];
    logic [7:0]  wd [0:31];
    logic [31:0] last_mc, last_if;

    mem_ctrl #(.ADDR_WIDTH(32), .IF_BYTES(4), .IO_HI(17)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
        .mc_w_data(mc_w_data), .mc_done(mc_done), .mc_r_data(mc_r_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'h1000: byte_at = 8'h11;
            32'h1001: byte_at = 8'h22;
            32'h1002: byte_at = 8'h33;
            32'h1003: byte_at = 8'h44;
            default:  byte_at = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Free-running RAM: data for the address of cycle N appears in cycle N+1
    always @(posedge clk) mem_din <= byte_at(mem_a);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Runs cycles A..A+n; control masks select the cycles where each signal is asserted
    task automatic run(input int n, input logic [31:0] rb_m, input logic [31:0] full_m,
                       input logic [31:0] stall_m);
        mc_m = '0; if_m = '0; wr_m = '0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            rollback       = rb_m[k];
            io_buffer_full = full_m[k];
            rdy            = !stall_m[k];
            #1;
            if (mc_done) begin
                mc_m[k] = 1'b1;
                last_mc = mc_r_data;
                mc_en   = 1'b0;
            end
            if (if_done) begin
                if_m[k] = 1'b1;
                last_if = if_data;
                if_en   = 1'b0;
            end
            if (mem_wr) begin
                wr_m[k] = 1'b1;
                wa[k]   = mem_a;
                wd[k]   = mem_dout;
            end
        end
        rollback = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;
    endtask

    task automatic req_mc(input logic wr, input logic [31:0] a, input logic [2:0] len,
                          input logic [31:0] d);
        mc_en = 1'b1; mc_wr = wr; mc_addr = a; mc_len = len; mc_w_data = d;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_en = 1'b0; if_addr = '0; mc_en = 1'b0; mc_wr = 1'b0;
        mc_addr = '0; mc_len = 3'd0; mc_w_data = '0;
        last_mc = '0; last_if = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus", {mem_a[23:0], mem_dout}, 32'h0);
        check("rst_flags", {29'd0, mem_wr, if_done, mc_done}, 32'h0);
        check("rst_data", if_data | mc_r_data, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word load
        req_mc(1'b0, 32'h1000, 3'd4, 32'h0);
        run(7, 32'h0, 32'h0, 32'h0);
        check("ld4_done", mc_m, 32'h40);
        check("ld4_data", last_mc, 32'h44332211);
        check("ld4_nowr", wr_m | if_m, 32'h0);

        // Halfword load, zero-extended
        req_mc(1'b0, 32'h1001, 3'd2, 32'h0);
        run(5, 32'h0, 32'h0, 32'h0);
        check("ld2_done", mc_m, 32'h10);
        check("ld2_data", last_mc, 32'h00003322);

        // Halfword store
        req_mc(1'b1, 32'h2002, 3'd2, 32'h0000BEEF);
        run(4, 32'h0, 32'h0, 32'h0);
        check("st2_wr", wr_m, 32'h6);
        check("st2_b0", {wa[1][23:0], wd[1]}, 32'h2002EF);
        check("st2_b1", {wa[2][23:0], wd[2]}, 32'h2003BE);
        check("st2_done", mc_m, 32'h8);

        // Simultaneous requests: data port first
        req_mc(1'b0, 32'h10, 3'd1, 32'h0);
        if_en = 1'b1; if_addr = 32'h0;
        run(11, 32'h0, 32'h0, 32'h0);
        check("arb_mc_done", mc_m, 32'h8);
        check("arb_mc_data", last_mc, 32'h000000B5);
        check("arb_if_done", if_m, 32'h400);
        check("arb_if_data", last_if, 32'hA6A7A4A5);

        // Fetch aborted by rollback, then re-accepted
        if_en = 1'b1; if_addr = 32'h20;
        run(11, 32'h8, 32'h0, 32'h0);
        check("rb_if_done", if_m, 32'h400);
        check("rb_if_data", last_if, 32'h86878485);
        check("rb_nowr", wr_m, 32'h0);

        // IO store throttled
        req_mc(1'b1, 32'h30000, 3'd1, 32'h41);
        run(6, 32'h0, 32'h7, 32'h0);
        check("io_wr", wr_m, 32'h10);
        check("io_byte", {wa[4][23:0], wd[4]}, 32'h03000041);
        check("io_done", mc_m, 32'h20);

        // Store survives rollback
        req_mc(1'b1, 32'h2100, 3'd4, 32'hA1B2C3D4);
        run(6, 32'h4, 32'h0, 32'h0);
        check("strb_wr", wr_m, 32'h1E);
        check("strb_b3", {wa[4][23:0], wd[4]}, 32'h2103A1);
        check("strb_done", mc_m, 32'h20);

        // Load with two stall cycles mid-transfer
        req_mc(1'b0, 32'h1000, 3'd4, 32'h0);
        run(9, 32'h0, 32'h0, 32'h18);
        check("stl_done", mc_m, 32'h100);
        check("stl_data", last_mc, 32'h44332211);

        // Store with a stall in its first byte cycle
        req_mc(1'b1, 32'h2200, 3'd2, 32'h00005A6B);
        run(5, 32'h0, 32'h0, 32'h2);
        check("sts_wr", wr_m, 32'hC);
        check("sts_b0", {wa[2][23:0], wd[2]}, 32'h22006B);
        check("sts_done", mc_m, 32'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
